swervolf_regbus_arb: RTL and testbench
======================================

// Module: swervolf_regbus_arb
// PURPOSE
//  Round-robin arbiter sharing the SoC controller register port (we/addr/be/wdata -> rdata)
//  between NUM_REQ requesters, e.g. the AXI-to-mem bridge and a debug/boot sequencer.
//  Grants one access per cycle and registers the winner onto the downstream port.
//  Routes read data back to the originator on the fixed register-port read latency.
// PARAMETERS
//  NUM_REQ  2   number of requesters, 1..8
//  AW       32  address width
//  DW       64  data width, multiple of 8; byte-enable width BEW = DW/8 (localparam)
// PORTS
//  clk          in   1            single clock, all logic on posedge
//  rst_n        in   1            asynchronous active-low reset
//  i_req        in   NUM_REQ      access request per requester, level
//  i_we         in   NUM_REQ      1 = write, 0 = read, per requester
//  i_addr       in   NUM_REQ*AW   request address, requester k at [k*AW +: AW]
//  i_be         in   NUM_REQ*BEW  byte enables, requester k at [k*BEW +: BEW]
//  i_wdata      in   NUM_REQ*DW   write data, requester k at [k*DW +: DW]
//  o_gnt        out  NUM_REQ      one-hot grant, combinational, same cycle as request
//  o_rvalid     out  NUM_REQ      one-hot read-data-valid, registered
//  o_rdata      out  DW           read data, shared by all requesters, valid with o_rvalid
//  o_reg_req    out  1            downstream access strobe, registered
//  o_reg_we     out  1            downstream write enable, registered
//  o_reg_addr   out  AW           downstream address, registered
//  o_reg_be     out  BEW          downstream byte enables, registered
//  o_reg_wdata  out  DW           downstream write data, registered
//  i_reg_rdata  in   DW           downstream read data, valid 1 cycle after o_reg_req read
// BEHAVIOUR
//  Reset (rst_n=0, async): ptr=0; o_reg_req/o_reg_we=0; o_reg_addr/be/wdata=0;
//   o_rvalid=0; o_rdata=0; pending-read pipeline cleared; o_gnt=0 while rst_n=0.
//  Arbitration (cycle N): scan i_req from index ptr upward, wrapping modulo NUM_REQ;
//   first set bit k wins; o_gnt[k]=1, all other o_gnt=0. No request -> o_gnt=0.
//  ptr update: on a grant to k, ptr <= (k+1) mod NUM_REQ; no grant -> ptr unchanged.
//   All requesters held high -> each granted exactly once per NUM_REQ cycles.
//  Request is consumed by o_gnt; requester drops or changes i_req/i_we/addr/be/wdata
//   after the grant cycle. Held i_req is a new request, re-arbitrated the next cycle.
//  Cycle N+1: o_reg_req=1; o_reg_we/addr/be/wdata = granted requester's cycle-N values.
//   Cycles with no grant -> o_reg_req=0, o_reg_we=0; addr/be/wdata hold previous values.
//  Reads: 2-stage id pipeline (valid + index) tracks each granted read.
//   Cycle N+2: o_rvalid[k]=1 for exactly one cycle; o_rdata <= i_reg_rdata.
//   Grant-to-data latency is 2 cycles. Back-to-back reads give one o_rvalid per cycle,
//   in grant order.
//  Writes: no response. o_rvalid is never asserted for a write; o_rdata holds its value.
//  be==0 accesses are forwarded unchanged; the arbiter does not filter them.
//  Read followed by write in consecutive cycles: the read's o_rvalid still fires at N+2.
//  NUM_REQ=1: ptr stays 0; o_gnt = i_req.
//  Reset mid-operation: in-flight grants and pending reads are discarded;
//   no o_rvalid is issued after rst_n deasserts for accesses granted before reset.
//  o_gnt depends only on i_req and ptr. No combinational path from i_reg_rdata to o_gnt.
// TESTING
//  1 Reset: rst_n=0 mid-read -> all outputs 0 asynchronously; no o_rvalid after release.
//  2 Single read: req0 rd addr=0x20 at N -> o_gnt=01 at N; o_reg_addr=0x20, we=0 at N+1;
//    rdata=0x1234 at N+1 -> o_rvalid=01, o_rdata=0x1234 at N+2.
//  3 Contention, NUM_REQ=2, both held 6 cycles from reset -> o_gnt 01,10,01,10,01,10.
//  4 Write: req1 we=1 be=0xF0 wdata=0xAABB_CCDD_0000_0000 -> o_reg_* carry these
//    values 1 cycle after grant; o_rvalid stays 0.
//  5 Pipelined: rd0, rd1, wr0, rd1 on 4 consecutive cycles -> o_rvalid 01,10,00,10
//    at +2 cycles each; o_rdata matches each sampled i_reg_rdata.
//  6 Fairness, NUM_REQ=3: req2 held while req0 toggles -> req2 granted within 3 cycles.

Source files
------------

// File: rtl/swervolf_regbus_arb.sv
// swervolf_regbus_arb: round-robin arbiter sharing the SoC controller register port
//   clk, rst_n        clock, asynchronous active-low reset
//   i_req/i_we        per-requester request level and write flag
//   i_addr/i_be/i_wdata  per-requester access fields, requester k in slice k
//   o_gnt             one-hot combinational grant
//   o_rvalid/o_rdata  read response, two cycles after the grant
//   o_reg_*           registered downstream access, one cycle after the grant
//   i_reg_rdata       downstream read data, one cycle after a read strobe
module swervolf_regbus_arb #(
    parameter int NUM_REQ = 2,
    parameter int AW = 32,
    parameter int DW = 64,
    localparam int BEW = DW / 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [NUM_REQ-1:0]     i_we,
    input  logic [NUM_REQ*AW-1:0]  i_addr,
    input  logic [NUM_REQ*BEW-1:0] i_be,
    input  logic [NUM_REQ*DW-1:0]  i_wdata,
    output logic [NUM_REQ-1:0]     o_gnt,
    output logic [NUM_REQ-1:0]     o_rvalid,
    output logic [DW-1:0]          o_rdata,
    output logic                   o_reg_req,
    output logic                   o_reg_we,
    output logic [AW-1:0]          o_reg_addr,
    output logic [BEW-1:0]         o_reg_be,
    output logic [DW-1:0]          o_reg_wdata,
    input  logic [DW-1:0]          i_reg_rdata
);
    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          any;
    logic          p1_v;
    logic [PW-1:0] p1_id;

    // Scan downward so the requester closest to ptr (scan order) is written last and wins.
    always_comb begin
        win = '0;
        any = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[(int'(ptr) + i) % NUM_REQ]) begin
                win = PW'((int'(ptr) + i) % NUM_REQ);
                any = 1'b1;
            end
        end
        o_gnt = (any && rst_n) ? NUM_REQ'(1) << win : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            o_reg_req   <= 1'b0;
            o_reg_we    <= 1'b0;
            o_reg_addr  <= '0;
            o_reg_be    <= '0;
            o_reg_wdata <= '0;
            p1_v        <= 1'b0;
            p1_id       <= '0;
            o_rvalid    <= '0;
            o_rdata     <= '0;
        end else begin
            o_reg_req <= any;
            o_reg_we  <= any & i_we[win];
            if (any) begin
                ptr         <= PW'((int'(win) + 1) % NUM_REQ);
                o_reg_addr  <= i_addr[int'(win)*AW +: AW];
                o_reg_be    <= i_be[int'(win)*BEW +: BEW];
                o_reg_wdata <= i_wdata[int'(win)*DW +: DW];
            end
            // Stage 1 marks the cycle the read is on the register port; stage 2 is o_rvalid.
            p1_v     <= any & ~i_we[win];
            p1_id    <= win;
            o_rvalid <= p1_v ? NUM_REQ'(1) << p1_id : '0;
            if (p1_v) o_rdata <= i_reg_rdata;
        end
    end
endmodule

// File: tb/tb_swervolf_regbus_arb.sv
// tb_swervolf_regbus_arb: directed vector table, corner sequences and a random run against a reference model
module tb_swervolf_regbus_arb;
    localparam logic [63:0] W = 64'hAABB_CCDD_0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [63:0] rdi = '0;

    logic [1:0] req2 = '0, we2 = '0, gnt2, rv2;
    logic [63:0] addr2 = '0;
    logic [15:0] be2 = '0;
    logic [127:0] wd2 = '0;
    logic [63:0] rdo2, rwd2;
    logic rreq2, rwe2;
    logic [31:0] raddr2;
    logic [7:0] rbe2;

    logic [2:0] req3 = '0, we3 = '0, gnt3, rv3;
    logic [95:0] addr3 = '0;
    logic [23:0] be3 = '0;
    logic [191:0] wd3 = '0;
    logic [63:0] rdo3, rwd3;
    logic rreq3, rwe3;
    logic [31:0] raddr3;
    logic [7:0] rbe3;

    logic [0:0] req1 = '0, we1 = '0, gnt1, rv1;
    logic [31:0] addr1 = '0;
    logic [7:0] be1 = '0;
    logic [63:0] wd1 = '0;
    logic [63:0] rdo1, rwd1;
    logic rreq1, rwe1;
    logic [31:0] raddr1;
    logic [7:0] rbe1;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    swervolf_regbus_arb #(.NUM_REQ(2)) u2 (
        .clk(clk), .rst_n(rst_n), .i_req(req2), .i_we(we2), .i_addr(addr2), .i_be(be2),
        .i_wdata(wd2), .o_gnt(gnt2), .o_rvalid(rv2), .o_rdata(rdo2), .o_reg_req(rreq2),
        .o_reg_we(rwe2), .o_reg_addr(raddr2), .o_reg_be(rbe2), .o_reg_wdata(rwd2),
        .i_reg_rdata(rdi)
    );
    swervolf_regbus_arb #(.NUM_REQ(3)) u3 (
        .clk(clk), .rst_n(rst_n), .i_req(req3), .i_we(we3), .i_addr(addr3), .i_be(be3),
        .i_wdata(wd3), .o_gnt(gnt3), .o_rvalid(rv3), .o_rdata(rdo3), .o_reg_req(rreq3),
        .o_reg_we(rwe3), .o_reg_addr(raddr3), .o_reg_be(rbe3), .o_reg_wdata(rwd3),
        .i_reg_rdata(rdi)
    );
    swervolf_regbus_arb #(.NUM_REQ(1)) u1 (
        .clk(clk), .rst_n(rst_n), .i_req(req1), .i_we(we1), .i_addr(addr1), .i_be(be1),
        .i_wdata(wd1), .o_gnt(gnt1), .o_rvalid(rv1), .o_rdata(rdo1), .o_reg_req(rreq1),
        .o_reg_we(rwe1), .o_reg_addr(raddr1), .o_reg_be(rbe1), .o_reg_wdata(rwd1),
        .i_reg_rdata(rdi)
    );

    typedef struct {
        logic [1:0]  req, we;
        logic [31:0] a0, a1;
        logic [7:0]  be1;
        logic [63:0] rd_in;
        logic [1:0]  gnt;
        logic        rreq, rwe;
        logic [31:0] raddr;
        logic [7:0]  rbe;
        logic [63:0] rwd;
        logic [1:0]  rv;
        logic [63:0] rd;
    } vec_t;

    typedef struct {
        int          g;
        logic        we;
        logic [31:0] a;
        logic [7:0]  be;
        logic [63:0] wd;
        logic [63:0] rdin;
    } hist_t;

    vec_t tbl[12];
    hist_t hq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference arbitration: first requester at or after ptr in circular order.
    function automatic int arb(input logic [7:0] r, input int p, input int n);
        for (int i = 0; i < n; i++)
            if (r[(p + i) % n]) return (p + i) % n;
        return -1;
    endfunction

    function automatic hist_t hist_at(input int back);
        hist_t h;
        h = '{g: -1, we: 1'b0, a: '0, be: '0, wd: '0, rdin: '0};
        if (hq.size() >= back) h = hq[hq.size() - back];
        return h;
    endfunction

    initial begin
        int mptr;
        int win;
        int hit;
        logic p_req1;
        logic [31:0] h_addr;
        logic [7:0] h_be;
        logic [63:0] h_wd, h_rd, e_rv;
        hist_t p1, p2, cur;

        tbl[0]  = '{2'b01, 2'b00, 32'h20,  32'h0,   8'hF0, 64'hDEAD, 2'b01, 1'b0, 1'b0, 32'h0,   8'h00, 64'h0, 2'b00, 64'h0};
        tbl[1]  = '{2'b00, 2'b00, 32'h0,   32'h0,   8'hF0, 64'h1234, 2'b00, 1'b1, 1'b0, 32'h20,  8'hFF, 64'h0, 2'b00, 64'h0};
        tbl[2]  = '{2'b00, 2'b00, 32'h0,   32'h0,   8'hF0, 64'hDEAD, 2'b00, 1'b0, 1'b0, 32'h20,  8'hFF, 64'h0, 2'b01, 64'h1234};
        tbl[3]  = '{2'b10, 2'b10, 32'h0,   32'h40,  8'hF0, 64'hDEAD, 2'b10, 1'b0, 1'b0, 32'h20,  8'hFF, 64'h0, 2'b00, 64'h1234};
        tbl[4]  = '{2'b00, 2'b00, 32'h0,   32'h0,   8'hF0, 64'hDEAD, 2'b00, 1'b1, 1'b1, 32'h40,  8'hF0, W,     2'b00, 64'h1234};
        tbl[5]  = '{2'b00, 2'b00, 32'h0,   32'h0,   8'hF0, 64'hDEAD, 2'b00, 1'b0, 1'b0, 32'h40,  8'hF0, W,     2'b00, 64'h1234};
        tbl[6]  = '{2'b01, 2'b00, 32'h100, 32'h0,   8'hF0, 64'hDEAD, 2'b01, 1'b0, 1'b0, 32'h40,  8'hF0, W,     2'b00, 64'h1234};
        tbl[7]  = '{2'b10, 2'b00, 32'h0,   32'h104, 8'hF0, 64'h1111, 2'b10, 1'b1, 1'b0, 32'h100, 8'hFF, 64'h0, 2'b00, 64'h1234};
        tbl[8]  = '{2'b01, 2'b01, 32'h108, 32'h0,   8'hF0, 64'h2222, 2'b01, 1'b1, 1'b0, 32'h104, 8'hF0, W,     2'b01, 64'h1111};
        tbl[9]  = '{2'b10, 2'b00, 32'h0,   32'h10C, 8'h00, 64'h3333, 2'b10, 1'b1, 1'b1, 32'h108, 8'hFF, 64'h0, 2'b10, 64'h2222};
        tbl[10] = '{2'b00, 2'b00, 32'h0,   32'h0,   8'hF0, 64'h4444, 2'b00, 1'b1, 1'b0, 32'h10C, 8'h00, W,     2'b00, 64'h2222};
        tbl[11] = '{2'b00, 2'b00, 32'h0,   32'h0,   8'hF0, 64'hDEAD, 2'b00, 1'b0, 1'b0, 32'h10C, 8'h00, W,     2'b10, 64'h4444};

        // Reset state, with requests present to show o_gnt is forced low.
        req2 = 2'b11;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 64'(gnt2), 64'h0);
        chk("rst_reg_req", 64'(rreq2), 64'h0);
        chk("rst_reg_addr", 64'(raddr2), 64'h0);
        chk("rst_rvalid", 64'(rv2), 64'h0);
        chk("rst_rdata", rdo2, 64'h0);
        req2 = '0;
        rst_n = 1'b1;

        // Directed vector table: single read, write, pipelined mix, be==0 forwarding.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            req2 = tbl[i].req;
            we2 = tbl[i].we;
            addr2 = {tbl[i].a1, tbl[i].a0};
            be2 = {tbl[i].be1, 8'hFF};
            wd2 = {W, 64'h0};
            rdi = tbl[i].rd_in;
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", i), 64'(gnt2), 64'(tbl[i].gnt));
            chk($sformatf("tbl%0d_reg_req", i), 64'(rreq2), 64'(tbl[i].rreq));
            chk($sformatf("tbl%0d_reg_we", i), 64'(rwe2), 64'(tbl[i].rwe));
            chk($sformatf("tbl%0d_reg_addr", i), 64'(raddr2), 64'(tbl[i].raddr));
            chk($sformatf("tbl%0d_reg_be", i), 64'(rbe2), 64'(tbl[i].rbe));
            chk($sformatf("tbl%0d_reg_wdata", i), rwd2, tbl[i].rwd);
            chk($sformatf("tbl%0d_rvalid", i), 64'(rv2), 64'(tbl[i].rv));
            chk($sformatf("tbl%0d_rdata", i), rdo2, tbl[i].rd);
        end

        // Reset while a read is on the register port: outputs clear at once, no late response.
        @(posedge clk); #1;
        req2 = 2'b01; we2 = 2'b00; addr2 = {32'h0, 32'h80}; rdi = 64'h5555;
        @(posedge clk); #1;
        req2 = 2'b00;
        #2 rst_n = 1'b0;
        req2 = 2'b11;
        #1;
        chk("midrst_gnt", 64'(gnt2), 64'h0);
        chk("midrst_reg_req", 64'(rreq2), 64'h0);
        chk("midrst_reg_addr", 64'(raddr2), 64'h0);
        chk("midrst_rvalid", 64'(rv2), 64'h0);
        chk("midrst_rdata", rdo2, 64'h0);
        @(negedge clk);
        req2 = 2'b00;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("postrst%0d_rvalid", i), 64'(rv2), 64'h0);
        end

        // Two requesters held high from reset alternate grants.
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            req2 = 2'b11; we2 = 2'b00;
            @(negedge clk);
            chk($sformatf("contend%0d_gnt", k), 64'(gnt2), (k % 2) ? 64'h2 : 64'h1);
        end
        @(posedge clk); #1;
        req2 = 2'b00;

        // Fairness with three requesters: req2 held while req0 toggles.
        hit = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            req3 = {1'b1, 1'b0, (k % 2 == 0)};
            @(negedge clk);
            if (gnt3[2]) hit = 1;
        end
        chk("fair_req2_granted", 64'(hit), 64'h1);
        @(posedge clk); #1;
        req3 = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;

        // Random traffic on the three-requester and single-requester instances.
        mptr = 0; p_req1 = 1'b0;
        h_addr = '0; h_be = '0; h_wd = '0; h_rd = '0;
        hq.delete();
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            req3 = 3'($urandom_range(0, 7));
            we3 = 3'($urandom_range(0, 7));
            addr3 = {$urandom, $urandom, $urandom};
            be3 = 24'($urandom);
            wd3 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rdi = {$urandom, $urandom};
            req1 = 1'($urandom_range(0, 1));
            @(negedge clk);
            win = arb(8'(req3), mptr, 3);
            p1 = hist_at(1);
            p2 = hist_at(2);
            if (p1.g >= 0) begin
                h_addr = p1.a; h_be = p1.be; h_wd = p1.wd;
            end
            e_rv = 64'h0;
            if (p2.g >= 0 && !p2.we) begin
                e_rv = 64'h1 << p2.g;
                h_rd = p1.rdin;
            end
            chk("rnd_gnt", 64'(gnt3), win >= 0 ? 64'h1 << win : 64'h0);
            chk("rnd_reg_req", 64'(rreq3), 64'(p1.g >= 0));
            chk("rnd_reg_we", 64'(rwe3), 64'(p1.g >= 0 && p1.we));
            chk("rnd_reg_addr", 64'(raddr3), 64'(h_addr));
            chk("rnd_reg_be", 64'(rbe3), 64'(h_be));
            chk("rnd_reg_wdata", rwd3, h_wd);
            chk("rnd_rvalid", 64'(rv3), e_rv);
            chk("rnd_rdata", rdo3, h_rd);
            chk("rnd1_gnt", 64'(gnt1), 64'(req1));
            chk("rnd1_reg_req", 64'(rreq1), 64'(p_req1));
            cur = '{g: win, we: 1'b0, a: '0, be: '0, wd: '0, rdin: rdi};
            if (win >= 0) begin
                cur.we = we3[win];
                cur.a = addr3[win*32 +: 32];
                cur.be = be3[win*8 +: 8];
                cur.wd = wd3[win*64 +: 64];
                mptr = (win + 1) % 3;
            end
            hq.push_back(cur);
            if (hq.size() > 2) void'(hq.pop_front());
            p_req1 = req1;
            if (c == 200) begin
                rst_n = 1'b0;
                req3 = 3'b111;
                #1;
                chk("rndrst_gnt", 64'(gnt3), 64'h0);
                chk("rndrst_reg_req", 64'(rreq3), 64'h0);
                chk("rndrst_rvalid", 64'(rv3), 64'h0);
                chk("rndrst_rdata", rdo3, 64'h0);
                req3 = '0; req1 = '0;
                #1 rst_n = 1'b1;
                mptr = 0; p_req1 = 1'b0;
                h_addr = '0; h_be = '0; h_wd = '0; h_rd = '0;
                hq.delete();
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
